// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode helpers for the iterative mul/div ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_LUI = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_DIV = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  localparam logic [3:0] OP_NOR = 4'hB;
  localparam logic [3:0] OP_CLZ = 4'hC;
  localparam logic [3:0] OP_CLO = 4'hD;
  localparam logic [3:0] OP_SLT = 4'hE;
  localparam logic [3:0] OP_EQ  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 1-bit-per-clock unsigned shift-add multiplier / restoring divider
// with sign correction applied combinationally on the final register contents.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic             i_sign,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_neg_p;
  logic               r_neg_r;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shl;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_prod;

  assign w_a_neg = i_sign & i_a[WIDTH-1];
  assign w_b_neg = i_sign & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Multiply: {acc,q} holds partial product and remaining multiplier bits.
  // Divide: {acc,q} holds partial remainder and quotient bits shifting in from the right.
  assign w_add  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mcand} : '0);
  assign w_shl  = {r_acc, r_q[WIDTH-1]};
  assign w_fits = (w_shl >= {1'b0, r_mcand});
  assign o_last = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_acc   <= '0;
      r_q     <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_p <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_acc   <= '0;
      r_q     <= w_a_mag;
      r_mcand <= w_b_mag;
      r_cnt   <= CNT_INIT;
      r_div   <= i_div;
      r_neg_p <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (i_step) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_div) begin
        // Remainder after a successful subtract is below the divisor, so WIDTH bits suffice.
        r_acc <= w_fits ? (w_shl[WIDTH-1:0] - r_mcand) : w_shl[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_fits};
      end else begin
        {r_acc, r_q} <= {w_add, r_q[WIDTH-1:1]};
      end
    end
  end

  assign w_prod = r_neg_p ? -{r_acc, r_q} : {r_acc, r_q};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      o_hi = r_neg_r ? -r_acc : r_acc;
      o_lo = r_neg_p ? -r_q : r_q;
    end
  end

endmodule

// File: rtl/iter_muldiv_alu.sv
// Registered ALU: single-cycle ops finish the clock after start; MUL/DIV run on the
// iterative core behind a busy/done handshake with Hi/Lo result registers.
module iter_muldiv_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             sign,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dbz;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_sc_lo;
  logic             w_sc_ovf;
  logic             w_wr;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;
  logic             w_novf;
  logic             w_ndbz;

  function automatic logic [WIDTH-1:0] lead_zeros(input logic [WIDTH-1:0] v);
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) seen = 1'b1;
      else if (!seen) n++;
    end
    return WIDTH'(n);
  endfunction

  assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_sh   = b[SHW-1:0];

  always_comb begin
    w_sc_lo  = '0;
    w_sc_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        w_sc_lo  = w_sum[WIDTH-1:0];
        w_sc_ovf = sign ? ((a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]))
                        : w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sc_lo  = w_diff[WIDTH-1:0];
        w_sc_ovf = sign ? ((a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]))
                        : w_diff[WIDTH];
      end
      OP_LUI: w_sc_lo = b << 16;
      OP_SLL: w_sc_lo = a << w_sh;
      OP_SRL: w_sc_lo = a >> w_sh;
      OP_SRA: w_sc_lo = $signed(a) >>> w_sh;
      OP_AND: w_sc_lo = a & b;
      OP_OR:  w_sc_lo = a | b;
      OP_XOR: w_sc_lo = a ^ b;
      OP_NOR: w_sc_lo = ~(a | b);
      OP_CLZ: w_sc_lo = lead_zeros(a);
      OP_CLO: w_sc_lo = lead_zeros(~a);
      OP_SLT: w_sc_lo = {{(WIDTH-1){1'b0}}, sign ? ($signed(a) < $signed(b)) : (a < b)};
      OP_EQ:  w_sc_lo = {{(WIDTH-1){1'b0}}, a == b};
      default: ;
    endcase
  end

  // Decide what (if anything) the result registers capture this cycle.
  always_comb begin
    w_wr   = 1'b0;
    w_load = 1'b0;
    w_nhi  = '0;
    w_nlo  = '0;
    w_novf = 1'b0;
    w_ndbz = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!is_iter(op)) begin
            w_wr   = 1'b1;
            w_nlo  = w_sc_lo;
            w_novf = w_sc_ovf;
          end else if ((op == OP_DIV) && (b == '0)) begin
            w_wr   = 1'b1;
            w_nhi  = a;
            w_nlo  = '1;
            w_ndbz = 1'b1;
          end else if ((op == OP_DIV) && sign && (a == MIN_S) && (b == '1)) begin
            w_wr   = 1'b1;
            w_nlo  = MIN_S;
            w_novf = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_FIX: begin
        w_wr  = 1'b1;
        w_nhi = w_core_hi;
        w_nlo = w_core_lo;
      end
      default: ;
    endcase
  end

  assign w_step = (r_state == ST_RUN);

  muldiv_iter #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_div  (op == OP_DIV),
    .i_sign (sign),
    .i_a    (a),
    .i_b    (b),
    .o_last (w_last),
    .o_hi   (w_core_hi),
    .o_lo   (w_core_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= w_wr;
      if (w_wr) begin
        r_hi   <= w_nhi;
        r_lo   <= w_nlo;
        r_zero <= ~|{w_nhi, w_nlo};
        r_ovf  <= w_novf;
        r_dbz  <= w_ndbz;
      end
      case (r_state)
        ST_IDLE: if (w_load) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
        end
        ST_RUN: if (w_last) r_state <= ST_FIX;
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result_hi   = r_hi;
  assign result_lo   = r_lo;
  assign zero        = r_zero;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_muldiv_alu.sv
// Self-checking bench: directed corner cases plus random ops against an arithmetic reference model.
module tb_iter_muldiv_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic        sign;
  logic        carry_in;
  logic [31:0] a, b;
  logic        busy, done, zero, overflow, div_by_zero;
  logic [31:0] result_hi, result_lo;

  logic        start8;
  logic [3:0]  op8;
  logic        sign8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8, ovf8, dbz8;
  logic [7:0]  hi8, lo8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iter_muldiv_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sign(sign), .carry_in(carry_in),
    .a(a), .b(b), .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  iter_muldiv_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .sign(sign8), .carry_in(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result_hi(hi8), .result_lo(lo8),
    .zero(zero8), .overflow(ovf8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic on the architectural definition of each op.
  task automatic model(input logic [3:0] o, input logic s, input logic c,
                       input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic ovf, output logic dbz);
    longint opa, opb, r, rm;
    logic [31:0] v;
    int n;
    opa = s ? longint'($signed(x)) : longint'(x);
    opb = s ? longint'($signed(y)) : longint'(y);
    hi = 32'h0; lo = 32'h0; ovf = 1'b0; dbz = 1'b0;
    case (o)
      OP_ADD, OP_SUB: begin
        r   = (o == OP_ADD) ? (opa + opb + longint'(c)) : (opa - opb);
        lo  = r[31:0];
        ovf = s ? (r > longint'(32'h7FFFFFFF) || r < -longint'(32'h80000000))
                : (r > longint'(32'hFFFFFFFF) || r < 0);
      end
      OP_MUL: begin
        r  = opa * opb;
        hi = r[63:32];
        lo = r[31:0];
      end
      OP_DIV: begin
        if (y == 32'h0) begin
          dbz = 1'b1; lo = 32'hFFFFFFFF; hi = x;
        end else if (s && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          ovf = 1'b1; lo = 32'h80000000;
        end else begin
          r  = opa / opb;
          rm = opa % opb;
          lo = r[31:0];
          hi = rm[31:0];
        end
      end
      OP_LUI: lo = {y[15:0], 16'h0};
      OP_SLL: lo = x << y[4:0];
      OP_SRL: lo = x >> y[4:0];
      OP_SRA: lo = $signed(x) >>> y[4:0];
      OP_AND: lo = x & y;
      OP_OR:  lo = x | y;
      OP_XOR: lo = x ^ y;
      OP_NOR: lo = ~(x | y);
      OP_CLZ, OP_CLO: begin
        v = (o == OP_CLZ) ? x : ~x;
        n = 0;
        while (n < 32 && v[31 - n] == 1'b0) n++;
        lo = 32'(n);
      end
      OP_SLT: lo = (opa < opb) ? 32'd1 : 32'd0;
      OP_EQ:  lo = (x == y) ? 32'd1 : 32'd0;
      default: ;
    endcase
  endtask

  // Issue one op and wait for done; optionally re-pulse start (as an ADD) at cycle N+repulse_at.
  task automatic do_op(input string tag, input logic [3:0] o, input logic s, input logic c,
                       input logic [31:0] x, input logic [31:0] y, input int repulse_at);
    logic [31:0] ehi, elo;
    logic eovf, edbz;
    int lat, nb, elat;
    bit iterative;
    model(o, s, c, x, y, ehi, elo, eovf, edbz);
    iterative = (o == OP_MUL) ||
                (o == OP_DIV && y != 0 && !(s && x == 32'h80000000 && y == 32'hFFFFFFFF));
    elat = iterative ? 34 : 1;
    start = 1'b1; op = o; sign = s; carry_in = c; a = x; b = y;
    lat = 0; nb = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) nb++;
      if (lat == repulse_at) begin
        start = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1;
      end
    end while (!done && lat < 100);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_cycles"}, nb, iterative ? 33 : 0);
    check({tag, "_hi"}, result_hi, ehi);
    check({tag, "_lo"}, result_lo, elo);
    check({tag, "_zero"}, zero, (ehi == 0 && elo == 0));
    check({tag, "_ovf"}, overflow, eovf);
    check({tag, "_dbz"}, div_by_zero, edbz);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat8;
    rst_n = 1'b0; start = 1'b0; op = OP_ADD; sign = 1'b0; carry_in = 1'b0; a = '0; b = '0;
    start8 = 1'b0; op8 = OP_ADD; sign8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", result_hi, 0);
    check("rst_lo", result_lo, 0);
    check("rst_zero", zero, 1);
    check("rst_ovf", overflow, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_s_ovf", OP_ADD, 1, 0, 32'h7FFFFFFF, 32'h1, 0);
    @(posedge clk); #1;
    check("hold_done", done, 0);
    check("hold_lo", result_lo, 32'h80000000);
    check("hold_ovf", overflow, 1);
    do_op("add_u", OP_ADD, 0, 0, 32'h7FFFFFFF, 32'h1, 0);
    do_op("add_u_carry", OP_ADD, 0, 1, 32'hFFFFFFFF, 32'h0, 0);
    do_op("sub_u_borrow", OP_SUB, 0, 0, 32'h3, 32'h5, 0);
    do_op("mul_neg", OP_MUL, 1, 0, 32'hFFFFFFFE, 32'h3, 0);
    do_op("div_neg", OP_DIV, 1, 0, 32'hFFFFFFF9, 32'h2, 0);
    do_op("div_zero", OP_DIV, 1, 0, 32'hFFFFFFF9, 32'h0, 0);
    do_op("div_min_m1", OP_DIV, 1, 0, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op("div_u_repulse", OP_DIV, 0, 0, 32'd64, 32'd7, 5);
    do_op("sra_b2b", OP_SRA, 0, 0, 32'h80000000, 32'hABCDEF18, 0);
    do_op("clz_zero", OP_CLZ, 0, 0, 32'h0, 32'h0, 0);
    do_op("clo_ones", OP_CLO, 0, 0, 32'hFFFFFFFF, 32'h0, 0);
    do_op("clz_bit16", OP_CLZ, 0, 0, 32'h00010000, 32'h0, 0);
    do_op("and_zero", OP_AND, 0, 0, 32'hF0, 32'h0F, 0);
    do_op("slt_s", OP_SLT, 1, 0, 32'hFFFFFFFF, 32'h1, 0);
    do_op("slt_u", OP_SLT, 0, 0, 32'hFFFFFFFF, 32'h1, 0);

    // Abort a multiply mid-flight with an asynchronous reset.
    start = 1'b1; op = OP_MUL; sign = 1'b0; a = 32'd12345; b = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", result_hi, 0);
    check("abort_lo", result_lo, 0);
    check("abort_zero", zero, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("mul_after_abort", OP_MUL, 0, 0, 32'd12345, 32'd678, 0);

    // Narrow instance: unsigned 0xFF * 0xFF.
    start8 = 1'b1; op8 = OP_MUL; sign8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    lat8 = 0;
    do begin
      @(posedge clk); #1;
      start8 = 1'b0;
      lat8++;
    end while (!done8 && lat8 < 50);
    check("w8_latency", lat8, 10);
    check("w8_hi", hi8, 8'hFE);
    check("w8_lo", lo8, 8'h01);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 15));
      do_op($sformatf("rand%0d_op%0h", i, ro), ro, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), pick(), pick(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
